// File: rtl/cache_sim_pkg.sv
// Shared types and default sizing for the cache simulator: arbiter FSM encoding
// and the core-count / address-width defaults also used by the datapath top.
package cache_sim_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_ADDR_W    = 32;

endpackage

// File: rtl/trace_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
// Zero latency; no flow control (pure function of req/last).
module rr_pick #(
   parameter int NUM_CORES = 4,
   parameter int ID_W      = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [ID_W-1:0]      last,
   output logic [ID_W-1:0]      gnt_id,
   output logic                 any
);

   localparam logic [ID_W:0]   START_INC = 1;
   localparam logic [ID_W-1:0] ID_INC    = 1;

   logic [2*NUM_CORES-1:0] req_dbl;
   logic [ID_W:0]          start;
   logic [NUM_CORES-1:0]   rot;
   logic [ID_W-1:0]        off;

   // Rotate so bit 0 is core last+1, take the lowest set bit, then rotate back.
   always_comb begin
      req_dbl = {req, req};
      start   = {1'b0, last} + START_INC;
      rot     = req_dbl[start +: NUM_CORES];
      off     = '0;
      for (int j = NUM_CORES - 1; j >= 0; j--) begin
         if (rot[j]) off = ID_W'(j);
      end
      gnt_id = last + ID_INC + off;
      any    = |req;
   end

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin arbiter sharing the cache-lookup datapath among per-core trace sources.
// Grant registered one cycle after request; grant held until update_lru or TIMEOUT cycles in WAIT.
module trace_arbiter
   import cache_sim_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int TIMEOUT   = 64,
   parameter int ID_W      = $clog2(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        req_valid,
   input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
   output logic [NUM_CORES-1:0]        req_ready,
   input  logic                        update_lru,
   output logic                        trace_ready,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [ID_W-1:0]             grant_id,
   output logic                        busy,
   output logic [31:0]                 issue_count,
   output logic                        timeout_err
);

   localparam int              TW        = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]   TIMER_INC = 1;

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         issue_count_q, issue_count_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                timeout_err_q, timeout_err_d;

   logic [ID_W-1:0]     pick_id;
   logic                pick_any;
   logic                timer_expired;
   logic [ADDR_W-1:0]   addr_arr [NUM_CORES];

   rr_pick #(
      .NUM_CORES (NUM_CORES),
      .ID_W      (ID_W)
   ) u_rr_pick (
      .req    (req_valid),
      .last   (last_q),
      .gnt_id (pick_id),
      .any    (pick_any)
   );

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   assign timer_expired = (timer_q == TIMER_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (update_lru || timer_expired) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      trace_ready = (state_q == ISSUE);
      busy        = (state_q != IDLE);
      req_ready   = '0;
      if (state_q == ISSUE) req_ready[grant_id_q] = 1'b1;
   end

   // Grant, counter, timer and sticky error bookkeeping.
   always_comb begin
      last_d        = last_q;
      grant_id_d    = grant_id_q;
      mem_addr_d    = mem_addr_q;
      issue_count_d = issue_count_q;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               last_d     = pick_id;
               grant_id_d = pick_id;
               mem_addr_d = addr_arr[pick_id];
            end
         end
         ISSUE: begin
            issue_count_d = issue_count_q + 32'd1;
            timer_d       = '0;
         end
         WAIT: begin
            if (!update_lru) begin
               if (timer_expired) timeout_err_d = 1'b1;
               else               timer_d       = timer_q + TIMER_INC;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q        <= ID_W'(NUM_CORES - 1);
         grant_id_q    <= '0;
         mem_addr_q    <= '0;
         issue_count_q <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         last_q        <= last_d;
         grant_id_q    <= grant_id_d;
         mem_addr_q    <= mem_addr_d;
         issue_count_q <= issue_count_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign grant_id    = grant_id_q;
   assign issue_count = issue_count_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Bench for trace_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_trace_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int TO = 8;
   localparam int IW = 2;

   logic            clk        = 1'b0;
   logic            rst_n      = 1'b0;
   logic [N-1:0]    req_valid  = '0;
   logic [N*AW-1:0] req_addr   = '0;
   logic            update_lru = 1'b0;
   logic [N-1:0]    req_ready;
   logic            trace_ready;
   logic [AW-1:0]   mem_addr;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic [31:0]     issue_count;
   logic            timeout_err;

   always #5 clk = ~clk;

   trace_arbiter #(
      .NUM_CORES (N),
      .ADDR_W    (AW),
      .TIMEOUT   (TO),
      .ID_W      (IW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_ready   (req_ready),
      .update_lru  (update_lru),
      .trace_ready (trace_ready),
      .mem_addr    (mem_addr),
      .grant_id    (grant_id),
      .busy        (busy),
      .issue_count (issue_count),
      .timeout_err (timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // Model: phase 0 = idle, 1 = issuing, 2 = waiting for completion.
   int            m_phase;
   int            m_last;
   int            m_gid;
   int            m_waited;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_cnt;
   bit            m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_phase  = 0;
      m_last   = N - 1;
      m_gid    = 0;
      m_waited = 0;
      m_addr   = '0;
      m_cnt    = '0;
      m_err    = 1'b0;
   endfunction

   function automatic void model_step();
      bit found;
      int c;
      case (m_phase)
         0: begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!found && req_valid[c]) begin
                  found   = 1'b1;
                  m_last  = c;
                  m_gid   = c;
                  m_addr  = req_addr[c*AW +: AW];
                  m_phase = 1;
               end
            end
         end
         1: begin
            m_cnt    = m_cnt + 32'd1;
            m_waited = 0;
            m_phase  = 2;
         end
         default: begin
            m_waited++;
            if (update_lru) begin
               m_phase = 0;
            end else if (m_waited == TO) begin
               m_err   = 1'b1;
               m_phase = 0;
            end
         end
      endcase
   endfunction

   task automatic compare_all();
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      if (m_phase == 1) exp_rdy[m_gid] = 1'b1;
      chk("trace_ready", trace_ready, (m_phase == 1));
      chk("req_ready",   req_ready,   exp_rdy);
      chk("busy",        busy,        (m_phase != 0));
      chk("mem_addr",    mem_addr,    m_addr);
      chk("grant_id",    grant_id,    m_gid);
      chk("issue_count", issue_count, m_cnt);
      chk("timeout_err", timeout_err, m_err);
   endtask

   always @(negedge clk) begin
      if (cmp_en) compare_all();
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_trace_ready", trace_ready, 0);
      chk("rst_req_ready",   req_ready,   0);
      chk("rst_mem_addr",    mem_addr,    0);
      chk("rst_grant_id",    grant_id,    0);
      chk("rst_busy",        busy,        0);
      chk("rst_issue_count", issue_count, 0);
      chk("rst_timeout_err", timeout_err, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_issue(output int gid);
      bit ok;
      ok  = 1'b0;
      gid = -1;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (trace_ready) begin
            ok  = 1'b1;
            gid = int'(grant_id);
         end
      end
      if (!ok) chk("wait_issue_bound", 0, 1);
   endtask

   task automatic set_addr(input int c, input logic [AW-1:0] a);
      req_addr[c*AW +: AW] = a;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      int gid;
      int seen [8];
      int exp_order [8];
      int tr_cnt;
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

      model_reset();
      cmp_en = 1'b1;
      for (int c = 0; c < N; c++) set_addr(c, $urandom());

      // Single request from core 2.
      do_reset();
      set_addr(2, 32'h0000_1A30);
      req_valid = 4'b0100;
      tick();
      chk("single_trace_ready", trace_ready, 1);
      chk("single_mem_addr",    mem_addr,    32'h0000_1A30);
      chk("single_grant_id",    grant_id,    2);
      chk("single_req_ready",   req_ready,   4'b0100);
      chk("model_single_gid",   m_gid,       2);
      req_valid = '0;
      tick();
      chk("single_issue_count", issue_count, 1);
      repeat (4) tick();
      chk("single_busy_before", busy, 1);
      update_lru = 1'b1;
      tick();
      update_lru = 1'b0;
      chk("single_busy_after", busy, 0);

      // All cores requesting, completion two cycles after each issue.
      do_reset();
      req_valid = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         wait_issue(gid);
         seen[g] = gid;
         tick();
         tick();
         update_lru = 1'b1;
         tick();
         update_lru = 1'b0;
      end
      for (int g = 0; g < 8; g++) chk($sformatf("rotate_grant%0d", g), seen[g], exp_order[g]);
      chk("rotate_issue_count", issue_count, 8);
      req_valid = '0;
      tick();

      // Timeout with no completion, then normal service with sticky error.
      req_valid = 4'b0010;
      wait_issue(gid);
      req_valid = '0;
      repeat (TO) tick();
      chk("timeout_err_early", timeout_err, 0);
      chk("timeout_busy_last_wait", busy, 1);
      tick();
      chk("timeout_err_set", timeout_err, 1);
      chk("timeout_idle", busy, 0);
      req_valid = 4'b0100;
      wait_issue(gid);
      chk("after_timeout_gid", gid, 2);
      req_valid = '0;
      tick();
      update_lru = 1'b1;
      tick();
      update_lru = 1'b0;
      chk("after_timeout_idle", busy, 0);
      chk("timeout_err_sticky", timeout_err, 1);

      // Completion pulse during ISSUE is ignored.
      do_reset();
      req_valid = 4'b0001;
      wait_issue(gid);
      req_valid  = '0;
      update_lru = 1'b1;
      tick();
      update_lru = 1'b0;
      chk("issue_pulse_ignored", busy, 1);
      update_lru = 1'b1;
      tick();
      update_lru = 1'b0;
      chk("issue_pulse_done", busy, 0);

      // Completion on the expiry cycle wins over the timeout.
      req_valid = 4'b0001;
      wait_issue(gid);
      req_valid = '0;
      repeat (TO) tick();
      update_lru = 1'b1;
      tick();
      update_lru = 1'b0;
      chk("expiry_pulse_idle", busy, 0);
      chk("expiry_pulse_no_err", timeout_err, 0);

      // Reset mid-WAIT restores the pointer.
      req_valid = 4'b0010;
      wait_issue(gid);
      req_valid = '0;
      tick();
      chk("midwait_busy", busy, 1);
      do_reset();
      req_valid = 4'b1010;
      wait_issue(gid);
      chk("post_reset_gid", gid, 1);
      req_valid = '0;
      tick();
      update_lru = 1'b1;
      tick();
      update_lru = 1'b0;

      // Withdrawn request is never granted.
      req_valid = 4'b0001;
      wait_issue(gid);
      req_valid = '0;
      tick();
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      update_lru = 1'b1;
      tick();
      update_lru = 1'b0;
      tr_cnt = 0;
      repeat (10) begin
         tick();
         if (trace_ready) tr_cnt++;
      end
      chk("withdrawn_no_issue", tr_cnt, 0);
      chk("withdrawn_idle", busy, 0);

      // Randomized traffic.
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if (req_valid[c]) begin
               if (req_ready[c] || $urandom_range(31) == 0) req_valid[c] = 1'b0;
            end else if ($urandom_range(2) == 0) begin
               req_valid[c] = 1'b1;
               set_addr(c, $urandom());
            end
         end
         update_lru = busy ? ($urandom_range(5) == 0) : ($urandom_range(7) == 0);
         tick();
      end
      req_valid  = '0;
      update_lru = 1'b0;
      repeat (TO + 4) tick();

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
